// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-port arbiter and clear sequencer for the register file
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              L_S,
    output logic [ADDR_W-1:0] Wt_addr,
    output logic [DATA_W-1:0] Wt_data,
    output logic              last_b
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              grant_a;
    logic              grant_b;
    logic              accept_ok;

    // Under contention the requester not granted last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            grant_a = last_b;
            grant_b = !last_b;
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    assign accept_ok = (state == IDLE) && !clr_req;
    assign a_ready   = grant_a && accept_ok;
    assign b_ready   = grant_b && accept_ok;
    assign clr_busy  = (state == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            L_S     <= 1'b0;
            Wt_addr <= '0;
            Wt_data <= '0;
            last_b  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= ADDR_W'(1);
                        L_S   <= 1'b0;
                    end else if (a_ready) begin
                        Wt_addr <= a_addr;
                        Wt_data <= a_data;
                        L_S     <= (a_addr != '0);
                        last_b  <= 1'b0;
                    end else if (b_ready) begin
                        Wt_addr <= b_addr;
                        Wt_data <= b_data;
                        L_S     <= (b_addr != '0);
                        last_b  <= 1'b1;
                    end else begin
                        L_S <= 1'b0;
                    end
                end
                CLEAR: begin
                    // r0 is hardwired, so the sweep covers 1..top register only.
                    L_S     <= 1'b1;
                    Wt_addr <= cnt;
                    Wt_data <= '0;
                    cnt     <= cnt + ADDR_W'(1);
                    if (cnt == '1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        clr_req;
    logic        clr_busy;
    logic        a_valid, a_ready;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid, b_ready;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        L_S;
    logic [4:0]  Wt_addr;
    logic [31:0] Wt_data;
    logic        last_b;

    logic [31:0] rf [0:31];

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .L_S(L_S), .Wt_addr(Wt_addr), .Wt_data(Wt_data), .last_b(last_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (L_S) rf[Wt_addr] <= Wt_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clr_req = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        edge1();
        edge1();
        rst_n = 1'b1;
        #1;
        chk("rst_L_S", L_S, 0);
        chk("rst_Wt_addr", Wt_addr, 0);
        chk("rst_Wt_data", Wt_data, 0);
        chk("rst_last_b", last_b, 1);
        chk("rst_clr_busy", clr_busy, 0);

        // single request from A
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h12345678;
        #1;
        chk("single_a_ready", a_ready, 1);
        chk("single_b_ready", b_ready, 0);
        edge1();
        a_valid = 1'b0;
        chk("single_L_S", L_S, 1);
        chk("single_addr", Wt_addr, 5);
        chk("single_data", Wt_data, 32'h12345678);
        chk("single_last_b", last_b, 0);
        edge1();
        chk("single_L_S_off", L_S, 0);
        chk("single_addr_hold", Wt_addr, 5);

        // asynchronous reset while L_S is high
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hAA;
        edge1();
        a_valid = 1'b0;
        chk("pre_rst_L_S", L_S, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_L_S", L_S, 0);
        chk("async_rst_addr", Wt_addr, 0);
        chk("async_rst_data", Wt_data, 0);
        chk("async_rst_last_b", last_b, 1);
        chk("async_rst_busy", clr_busy, 0);
        edge1();
        rst_n = 1'b1;

        // contention on r3: A, B, A, B
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA0000003;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'hB0000003;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_a_ready", a_ready, (i % 2 == 0));
            chk("cont_b_ready", b_ready, (i % 2 == 1));
            edge1();
            chk("cont_L_S", L_S, 1);
            chk("cont_data", Wt_data, (i % 2 == 0) ? 32'hA0000003 : 32'hB0000003);
            chk("cont_last_b", last_b, (i % 2 == 1));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        edge1();
        chk("cont_r3_final", rf[3], 32'hB0000003);
        chk("cont_idle_L_S", L_S, 0);

        // request to r0 is consumed without a write
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
        #1;
        chk("r0_b_ready", b_ready, 1);
        edge1();
        b_valid = 1'b0;
        chk("r0_L_S", L_S, 0);
        chk("r0_addr", Wt_addr, 0);
        chk("r0_last_b", last_b, 1);

        // clear sequence with A pending
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        clr_req = 1'b1;
        #1;
        chk("clr_a_blocked", a_ready, 0);
        edge1();
        clr_req = 1'b0;
        chk("clr_busy_E0", clr_busy, 1);
        chk("clr_L_S_E0", L_S, 0);
        chk("clr_a_ready_E0", a_ready, 0);
        for (int k = 1; k <= 31; k++) begin
            edge1();
            if (k == 5) clr_req = 1'b1;
            if (k == 6) clr_req = 1'b0;
            #1;
            chk("clr_L_S", L_S, 1);
            chk("clr_addr", Wt_addr, k);
            chk("clr_data", Wt_data, 0);
            chk("clr_busy", clr_busy, (k < 31));
            chk("clr_a_ready", a_ready, (k == 31));
        end
        edge1();
        a_valid = 1'b0;
        chk("post_clr_L_S", L_S, 1);
        chk("post_clr_addr", Wt_addr, 9);
        chk("post_clr_data", Wt_data, 32'h99);
        chk("post_clr_busy", clr_busy, 0);
        chk("post_clr_r3", rf[3], 0);
        chk("post_clr_r31", rf[31], 0);

        // reset in the middle of a clear
        clr_req = 1'b1;
        edge1();
        clr_req = 1'b0;
        repeat (10) edge1();
        chk("mid_clr_addr", Wt_addr, 10);
        chk("mid_clr_busy", clr_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_L_S", L_S, 0);
        chk("mid_rst_busy", clr_busy, 0);
        edge1();
        rst_n = 1'b1;
        b_valid = 1'b1; b_addr = 5'd12; b_data = 32'h1212;
        #1;
        chk("after_rst_b_ready", b_ready, 1);
        edge1();
        b_valid = 1'b0;
        chk("after_rst_L_S", L_S, 1);
        chk("after_rst_addr", Wt_addr, 12);
        chk("after_rst_data", Wt_data, 32'h1212);
        chk("after_rst_busy", clr_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
